// File: rtl/lsu_pkg.sv
// Shared types and constants for the bus-attached load/store stage.
// Opcodes, funct3 codes, FSM states, exception codes and access sizes.
package lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_FAULT    = 2'd2
    } exc_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } size_e;

    typedef struct packed {
        size_e size;
        logic  uns;
        logic  mem_to_reg;
    } lsu_op_t;

    function automatic logic is_aligned(
        input size_e      size,
        input logic [2:0] a
    );
        logic ok;
        ok = 1'b1;
        unique case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = ~a[0];
            SZ_W:    ok = (a[1:0] == 2'b00);
            default: ok = (a == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_bus_stage_lane_align.sv
// Byte-lane steering: strobe and store-data shift toward the lane,
// load-data shift back to bit 0 then sign/zero extension.
// Ports: size/uns/off select the access; wdata_in/rdata_in raw data;
// wstrb/wdata/rdata are the aligned results.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [OFF_W-1:0]  off,
    input  logic [XLEN-1:0]   wdata_in,
    input  logic [XLEN-1:0]   rdata_in,
    output logic [XLEN/8-1:0] wstrb,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);

    localparam int STRB_W = XLEN / 8;

    size_e             sz;
    logic [STRB_W-1:0] mask;
    logic [OFF_W+2:0]  bit_sh;
    logic [XLEN-1:0]   rsh;

    assign sz     = size_e'(size);
    assign bit_sh = {off, 3'b000};
    assign wstrb  = mask << off;
    assign wdata  = wdata_in << bit_sh;
    assign rsh    = rdata_in >> bit_sh;

    always_comb begin
        mask = '1;
        unique case (sz)
            SZ_B:    mask = STRB_W'(1);
            SZ_H:    mask = STRB_W'(3);
            SZ_W:    mask = STRB_W'(15);
            default: mask = '1;
        endcase
    end

    // Size casts of a signed operand sign-extend.
    always_comb begin
        rdata = rsh;
        unique case (sz)
            SZ_B: begin
                if (uns) rdata = XLEN'(rsh[7:0]);
                else     rdata = XLEN'($signed(rsh[7:0]));
            end
            SZ_H: begin
                if (uns) rdata = XLEN'(rsh[15:0]);
                else     rdata = XLEN'($signed(rsh[15:0]));
            end
            SZ_W: begin
                if (uns) rdata = XLEN'(rsh[31:0]);
                else     rdata = XLEN'($signed(rsh[31:0]));
            end
            default: rdata = rsh;
        endcase
    end

endmodule

// File: rtl/lsu_bus_stage.sv
// Load/store stage over a valid/ready request/response bus (IDLE/REQ/
// WAIT/DONE). Ports: in_* upstream op, bus_req_*/bus_resp_* memory bus,
// out_* one-cycle write-back pulse. Optional WAIT timeout: LSU_TIMEOUT_EN.
module lsu_bus_stage
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic              in_mem_to_reg,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic              bus_req_we,
    output logic [XLEN/8-1:0] bus_req_wstrb,
    output logic [XLEN-1:0]   bus_req_wdata,
    input  logic              bus_resp_valid,
    input  logic [XLEN-1:0]   bus_resp_rdata,
    input  logic              bus_resp_err,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_data,
    output logic [1:0]        out_exc
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    state_e            state;
    lsu_op_t           op_q;
    logic [OFF_W-1:0]  off_q;
    logic [XLEN-1:0]   alu_q;

    logic [6:0]        opc;
    logic [2:0]        f3;
    logic              ld_ok;
    logic              st_ok;
    logic              is_ld;
    logic              is_st;
    logic              is_mem;
    logic              misal;
    size_e             dec_size;
    logic [ADDR_W-1:0] addr_c;

    size_e             la_size;
    logic              la_uns;
    logic [OFF_W-1:0]  la_off;
    logic [STRB_W-1:0] la_wstrb;
    logic [XLEN-1:0]   la_wdata;
    logic [XLEN-1:0]   la_rdata;

    logic              unused;

    assign opc      = in_instr[6:0];
    assign f3       = in_instr[14:12];
    assign dec_size = size_e'(f3[1:0]);

    // Doubleword forms only exist on a 64-bit datapath.
    always_comb begin
        ld_ok = 1'b0;
        st_ok = 1'b0;
        unique case (f3)
            F3_B, F3_H, F3_W: begin
                ld_ok = 1'b1;
                st_ok = 1'b1;
            end
            F3_BU, F3_HU: ld_ok = 1'b1;
            F3_D: begin
                ld_ok = (XLEN == 64);
                st_ok = (XLEN == 64);
            end
            F3_WU:   ld_ok = (XLEN == 64);
            default: ;
        endcase
    end

    assign is_ld  = (opc == OP_LOAD) && ld_ok;
    assign is_st  = (opc == OP_STORE) && st_ok;
    assign is_mem = is_ld || is_st;
    assign misal  = is_mem && !is_aligned(dec_size, in_alu[2:0]);
    assign addr_c = ADDR_W'(in_alu) & ~ADDR_W'(STRB_W - 1);

    // Store lanes come from the incoming op; load lanes from the latched op.
    always_comb begin
        la_size = op_q.size;
        la_uns  = op_q.uns;
        la_off  = off_q;
        if (state == ST_IDLE) begin
            la_size = dec_size;
            la_uns  = f3[2];
            la_off  = in_alu[OFF_W-1:0];
        end
    end

    lsu_lane_align #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_align (
        .size     (la_size),
        .uns      (la_uns),
        .off      (la_off),
        .wdata_in (in_rs2),
        .rdata_in (bus_resp_rdata),
        .wstrb    (la_wstrb),
        .wdata    (la_wdata),
        .rdata    (la_rdata)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;
    assign unused = ^{in_instr[31:15], in_instr[11:7]};
`else
    assign unused = ^{in_instr[31:15], in_instr[11:7], TIMEOUT_CYCLES[0]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            in_ready      <= 1'b1;
            bus_req_valid <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_we    <= 1'b0;
            bus_req_wstrb <= '0;
            bus_req_wdata <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_exc       <= EXC_NONE;
            op_q          <= '0;
            off_q         <= '0;
            alu_q         <= '0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        alu_q    <= in_alu;
                        if (!is_mem || misal) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            out_exc   <= misal ? EXC_MISALIGN : EXC_NONE;
                            out_data  <= misal ? '0 : in_alu;
                        end else begin
                            state           <= ST_REQ;
                            bus_req_valid   <= 1'b1;
                            bus_req_addr    <= addr_c;
                            bus_req_we      <= is_st;
                            bus_req_wstrb   <= la_wstrb;
                            bus_req_wdata   <= la_wdata;
                            op_q.size       <= dec_size;
                            op_q.uns        <= f3[2];
                            op_q.mem_to_reg <= in_mem_to_reg;
                            off_q           <= in_alu[OFF_W-1:0];
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        state         <= ST_WAIT;
`ifdef LSU_TIMEOUT_EN
                        tmo_cnt       <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (bus_resp_valid) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        if (bus_resp_err) begin
                            out_exc  <= EXC_FAULT;
                            out_data <= '0;
                        end else begin
                            out_exc  <= EXC_NONE;
                            out_data <= op_q.mem_to_reg ? la_rdata : alu_q;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        out_exc   <= EXC_FAULT;
                        out_data  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_stage.sv
// Randomised self-checking bench for lsu_bus_stage (XLEN=32) against a
// byte-addressed memory model; timeout case only with LSU_TIMEOUT_EN.
module tb_lsu_bus_stage;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_alu;
    logic [XLEN-1:0]   in_rs2;
    logic              in_mem_to_reg;
    logic              bus_req_valid;
    logic              bus_req_ready;
    logic [ADDR_W-1:0] bus_req_addr;
    logic              bus_req_we;
    logic [XLEN/8-1:0] bus_req_wstrb;
    logic [XLEN-1:0]   bus_req_wdata;
    logic              bus_resp_valid;
    logic [XLEN-1:0]   bus_resp_rdata;
    logic              bus_resp_err;
    logic              out_valid;
    logic [XLEN-1:0]   out_data;
    logic [1:0]        out_exc;

    always #5 clk = ~clk;

    lsu_bus_stage #(
        .XLEN           (XLEN),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_alu         (in_alu),
        .in_rs2         (in_rs2),
        .in_mem_to_reg  (in_mem_to_reg),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_req_addr   (bus_req_addr),
        .bus_req_we     (bus_req_we),
        .bus_req_wstrb  (bus_req_wstrb),
        .bus_req_wdata  (bus_req_wdata),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_rdata (bus_resp_rdata),
        .bus_resp_err   (bus_resp_err),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_exc        (out_exc)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [int unsigned];
    logic [2:0]  lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (mem.exists(k)) return mem[k];
        return k * 32'h9E37_79B9;
    endfunction

    task automatic do_op(
        input logic [6:0]  opc,
        input logic [2:0]  f3,
        input logic [31:0] alu,
        input logic [31:0] rs2,
        input logic        m2r,
        input int          rdly,
        input int          pdly,
        input logic        err,
        input logic        early
    );
        bit          is_ld;
        bit          is_st;
        bit          mis;
        int          n;
        int          off;
        int          w;
        logic [31:0] word;
        logic [31:0] v;
        logic [31:0] msk;
        logic [31:0] exp_d;
        logic [31:0] exp_a;
        logic [3:0]  exp_s;
        logic [31:0] exp_w;
        logic [31:0] nw;

        is_ld = (opc == 7'h03) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        is_st = (opc == 7'h23) && (f3 inside {3'd0, 3'd1, 3'd2});
        n     = 1 << f3[1:0];
        off   = int'(alu % 4);
        mis   = (is_ld || is_st) && ((alu % n) != 0);

        w = 0;
        while (!in_ready && w < 10) begin
            step();
            w++;
        end
        if (!in_ready) check("ready_timeout", in_ready, 1);

        in_valid      = 1'b1;
        in_instr      = {17'h0, f3, 5'h0, opc};
        in_alu        = alu;
        in_rs2        = rs2;
        in_mem_to_reg = m2r;
        step();
        in_valid = 1'b0;

        if (!(is_ld || is_st) || mis) begin
            check("fast_valid", out_valid, 1);
            check("fast_noreq", bus_req_valid, 0);
            check("fast_exc", out_exc, mis ? 2'd1 : 2'd0);
            check("fast_data", out_data, mis ? 32'd0 : alu);
        end else begin
            exp_a = alu & ~32'd3;
            exp_s = 4'(((1 << n) - 1) << off);
            exp_w = rs2 << (8 * off);
            for (int i = 0; i <= rdly; i++) begin
                if (i > 0) step();
                check("req_valid", bus_req_valid, 1);
                check("req_addr", bus_req_addr, exp_a);
                check("req_we", bus_req_we, is_st);
                if (is_st) begin
                    check("req_wstrb", bus_req_wstrb, exp_s);
                    check("req_wdata", bus_req_wdata, exp_w);
                end
                check("req_noout", out_valid, 0);
            end
            bus_req_ready = 1'b1;
            if (early) begin
                bus_resp_valid = 1'b1;
                bus_resp_rdata = 32'hBAD0_BAD0;
                bus_resp_err   = 1'b1;
            end
            step();
            bus_req_ready  = 1'b0;
            bus_resp_valid = 1'b0;
            check("req_drop", bus_req_valid, 0);
            for (int i = 0; i < pdly; i++) begin
                check("wait_noout", out_valid, 0);
                step();
            end
            check("wait_noout", out_valid, 0);
            word           = rd_word(alu);
            bus_resp_valid = 1'b1;
            bus_resp_rdata = is_ld ? word : $urandom;
            bus_resp_err   = err;
            step();
            bus_resp_valid = 1'b0;
            bus_resp_err   = 1'b0;

            msk = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
            v   = (word >> (8 * off)) & msk;
            if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~msk;
            if (err)              exp_d = 0;
            else if (is_ld && m2r) exp_d = v;
            else                   exp_d = alu;

            if (is_st && !err) begin
                nw = word;
                for (int b = 0; b < n; b++)
                    nw[8*(off+b) +: 8] = rs2[8*b +: 8];
                mem[alu >> 2] = nw;
            end
            check("resp_valid", out_valid, 1);
            check("resp_exc", out_exc, err ? 2'd2 : 2'd0);
            check("resp_data", out_data, exp_d);
        end
        step();
        check("pulse_end", out_valid, 0);
        check("ready_back", in_ready, 1);
    endtask

    initial begin
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] alu;
        int          kind;
        int          n;

        rst            = 1'b1;
        in_valid       = 1'b0;
        in_instr       = '0;
        in_alu         = '0;
        in_rs2         = '0;
        in_mem_to_reg  = 1'b0;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        bus_resp_rdata = '0;
        bus_resp_err   = 1'b0;

        #2 rst = 1'b0;
        #2;
        check("rst_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_req_valid", bus_req_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_exc", out_exc, 0);
        check("rst_req_addr", bus_req_addr, 0);
        check("rst_wstrb", bus_req_wstrb, 0);
        step();
        step();
        rst = 1'b1;
        step();

        do_op(7'h23, 3'd2, 32'h1004, 32'hDEAD_BEEF, 0, 0, 1, 0, 0);
        do_op(7'h03, 3'd2, 32'h1004, 32'h0, 1, 2, 0, 0, 1);
        mem[32'h1004 >> 2] = 32'h80FF_0000;
        do_op(7'h03, 3'd0, 32'h1007, 32'h0, 1, 0, 0, 0, 0);
        do_op(7'h03, 3'd4, 32'h1007, 32'h0, 1, 1, 2, 0, 0);
        do_op(7'h23, 3'd1, 32'h2002, 32'h0000_1234, 0, 0, 0, 0, 0);
        do_op(7'h03, 3'd2, 32'h3001, 32'h0, 1, 0, 0, 0, 0);
        do_op(7'h03, 3'd2, 32'h1008, 32'h0, 1, 5, 1, 1, 0);
        do_op(7'h13, 3'd0, 32'h0000_0055, 32'h7, 0, 0, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 9);
            alu  = 32'h1000 + $urandom_range(0, 63);
            if (kind < 4) begin
                opc = 7'h03;
                f3  = lf3[$urandom_range(0, 4)];
            end else if (kind < 8) begin
                opc = 7'h23;
                f3  = 3'($urandom_range(0, 2));
            end else if (kind == 8) begin
                opc = 7'h13;
                f3  = 3'($urandom_range(0, 7));
                alu = $urandom;
            end else begin
                opc = ($urandom_range(0, 1) == 0) ? 7'h03 : 7'h23;
                f3  = 3'b011 + 3'($urandom_range(0, 1)) * 3'b100;
            end
            do_op(opc, f3, alu, $urandom, opc == 7'h03,
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
        end

        // Reset while waiting for a response; the late response must vanish.
        in_valid      = 1'b1;
        in_instr      = {17'h0, 3'd2, 5'h0, 7'h03};
        in_alu        = 32'h1010;
        in_mem_to_reg = 1'b1;
        step();
        in_valid      = 1'b0;
        bus_req_ready = 1'b1;
        step();
        bus_req_ready = 1'b0;
        step();
        rst = 1'b0;
        #2;
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_req", bus_req_valid, 0);
        check("mid_rst_out", out_valid, 0);
        step();
        rst            = 1'b1;
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 32'h1234_5678;
        step();
        bus_resp_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) n++;
            step();
        end
        check("late_resp_ignored", n, 0);
        check("late_resp_ready", in_ready, 1);

`ifdef LSU_TIMEOUT_EN
        in_valid = 1'b1;
        in_instr = {17'h0, 3'd2, 5'h0, 7'h03};
        in_alu   = 32'h1020;
        step();
        in_valid      = 1'b0;
        bus_req_ready = 1'b1;
        step();
        bus_req_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("tmo_cycles", n, 8);
        check("tmo_exc", out_exc, 2);
        check("tmo_data", out_data, 0);
        step();
        check("tmo_ready", in_ready, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
